// File: rtl/pwm_demod.sv
// PWM stream demodulator: recovers the per-frame duty as a W-bit sample and
// measures the waveform period in frames between upward midscale crossings.
//   state  | meaning
//   IDLE   | waiting for a rising edge to align frame position 0
//   LOCKED | counting high cycles per 2^W-cycle frame
module pwm_demod #(
  parameter int W             = 8,
  parameter int PER_W         = 16,
  parameter int SILENT_FRAMES = 4
) (
  input  logic             clk,
  input  logic             NRST,
  input  logic             en_i,
  input  logic             pwm_i,
  output logic [W-1:0]     sample_o,
  output logic             sample_valid_o,
  output logic [PER_W-1:0] period_o,
  output logic             period_valid_o,
  output logic             sync_err_o,
  output logic             locked_o,
  output logic             silent_o
);
  localparam int AW    = W + 1;
  localparam int SIL_W = $clog2(SILENT_FRAMES + 1);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  state_t           state_q;
  logic             pwm_m_q, pwm_s_q, pwm_d_q;
  logic [W-1:0]     pos_q;
  logic [AW-1:0]    acc_q;
  logic [W-1:0]     sample_q;
  logic             sample_valid_q;
  logic [PER_W-1:0] period_q;
  logic             period_valid_q;
  logic             sync_err_q;
  logic             locked_q;
  logic             silent_q;
  logic [PER_W-1:0] frame_cnt_q;
  logic             armed_q;
  logic             prev_above_q;
  logic [SIL_W-1:0] zero_cnt_q;

  logic             rise;
  logic             misaligned;
  logic             frame_end;
  logic [AW-1:0]    total_d;
  logic [W-1:0]     sample_d;
  logic [SIL_W-1:0] zero_cnt_d;
  logic             silent_rise;
  logic [PER_W-1:0] frame_cnt_d;

  always_ff @(posedge clk or negedge NRST) begin
    if (!NRST) begin
      pwm_m_q <= 1'b0;
      pwm_s_q <= 1'b0;
      pwm_d_q <= 1'b0;
    end else begin
      pwm_m_q <= pwm_i;
      pwm_s_q <= pwm_m_q;
      pwm_d_q <= pwm_s_q;
    end
  end

  assign rise        = pwm_s_q & ~pwm_d_q;
  assign misaligned  = rise && (pos_q != '0);
  // A misaligned rise on the last position aborts the frame instead of ending it.
  assign frame_end   = (pos_q == {W{1'b1}}) && !misaligned;
  assign total_d     = acc_q + {{W{1'b0}}, pwm_s_q};
  assign sample_d    = total_d[W] ? {W{1'b1}} : total_d[W-1:0];
  assign zero_cnt_d  = (zero_cnt_q == SIL_W'(SILENT_FRAMES)) ? zero_cnt_q
                                                             : zero_cnt_q + SIL_W'(1);
  assign silent_rise = frame_end && (sample_d == '0) &&
                       (zero_cnt_d == SIL_W'(SILENT_FRAMES)) && !silent_q;
  assign frame_cnt_d = (&frame_cnt_q) ? frame_cnt_q : frame_cnt_q + PER_W'(1);

  always_ff @(posedge clk or negedge NRST) begin
    if (!NRST) begin
      state_q        <= IDLE;
      pos_q          <= '0;
      acc_q          <= '0;
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      sync_err_q     <= 1'b0;
      locked_q       <= 1'b0;
      silent_q       <= 1'b1;
      frame_cnt_q    <= '0;
      armed_q        <= 1'b0;
      prev_above_q   <= 1'b0;
      zero_cnt_q     <= '0;
    end else begin
      sample_valid_q <= 1'b0;
      period_valid_q <= 1'b0;
      sync_err_q     <= 1'b0;
      locked_q       <= en_i && (state_q == LOCKED);
      if (!en_i || (state_q == IDLE)) begin
        state_q      <= IDLE;
        pos_q        <= '0;
        acc_q        <= '0;
        frame_cnt_q  <= '0;
        armed_q      <= 1'b0;
        prev_above_q <= 1'b0;
        zero_cnt_q   <= '0;
        silent_q     <= 1'b1;
        if (en_i && rise) begin
          state_q <= LOCKED;
          pos_q   <= W'(1);
          acc_q   <= AW'(1);
        end
      end else begin
        pos_q <= pos_q + W'(1);
        acc_q <= total_d;
        if (misaligned) begin
          sync_err_q <= 1'b1;
          pos_q      <= W'(1);
          acc_q      <= AW'(1);
        end else if (frame_end) begin
          sample_q       <= sample_d;
          sample_valid_q <= 1'b1;
          acc_q          <= '0;
          if (sample_d == '0) begin
            zero_cnt_q <= zero_cnt_d;
            if (zero_cnt_d == SIL_W'(SILENT_FRAMES))
              silent_q <= 1'b1;
          end else begin
            zero_cnt_q <= '0;
            silent_q   <= 1'b0;
          end
        end
        // Crossing detection runs one cycle behind the sample strobe.
        if (sample_valid_q) begin
          prev_above_q <= sample_q[W-1];
          if (sample_q[W-1] && !prev_above_q) begin
            frame_cnt_q <= '0;
            if (armed_q) begin
              period_q       <= frame_cnt_d;
              period_valid_q <= 1'b1;
            end else begin
              armed_q <= 1'b1;
            end
          end else begin
            frame_cnt_q <= frame_cnt_d;
          end
        end
        if (silent_rise)
          armed_q <= 1'b0;
      end
    end
  end

  assign sample_o       = sample_q;
  assign sample_valid_o = sample_valid_q;
  assign period_o       = period_q;
  assign period_valid_o = period_valid_q;
  assign sync_err_o     = sync_err_q;
  assign locked_o       = locked_q;
  assign silent_o       = silent_q;

endmodule

// File: tb/tb_pwm_demod.sv
// Self-checking bench for pwm_demod: frame-level stimulus against a
// behavioural model of samples, silence and crossing periods.
`timescale 1ns/1ps
module tb_pwm_demod;
  localparam int W     = 8;
  localparam int PER_W = 16;
  localparam int SIL   = 4;
  localparam int FRAME = 256;
  localparam int LAT   = 258;  // drive of frame start to visible sample strobe

  logic             clk = 1'b0;
  logic             NRST = 1'b0;
  logic             en_i = 1'b0;
  logic             pwm_i = 1'b0;
  logic [W-1:0]     sample_o;
  logic             sample_valid_o;
  logic [PER_W-1:0] period_o;
  logic             period_valid_o;
  logic             sync_err_o;
  logic             locked_o;
  logic             silent_o;

  pwm_demod #(.W(W), .PER_W(PER_W), .SILENT_FRAMES(SIL)) dut (
    .clk(clk), .NRST(NRST), .en_i(en_i), .pwm_i(pwm_i),
    .sample_o(sample_o), .sample_valid_o(sample_valid_o),
    .period_o(period_o), .period_valid_o(period_valid_o),
    .sync_err_o(sync_err_o), .locked_o(locked_o), .silent_o(silent_o)
  );

  always #50 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; int val; bit sil; } ev_t;
  ev_t sv_q[$];
  ev_t pv_q[$];
  int  se_q[$];
  ev_t mon_s, mon_p;
  int  sv_b, pv_b, se_b;

  always @(negedge clk) begin
    if (NRST && sample_valid_o) begin
      mon_s.cyc = cyc; mon_s.val = int'(sample_o); mon_s.sil = silent_o;
      sv_q.push_back(mon_s);
    end
    if (NRST && period_valid_o) begin
      mon_p.cyc = cyc; mon_p.val = int'(period_o); mon_p.sil = silent_o;
      pv_q.push_back(mon_p);
    end
    if (NRST && sync_err_o) se_q.push_back(cyc);
  end

  int passed = 0;
  int total  = 0;

  int duty_a[$];
  int exp_s[$];
  bit exp_sil[$];
  int exp_pidx[$];
  int exp_pval[$];

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      pwm_i = v;
      step();
    end
  endtask

  task automatic drive_frame(input int d);
    drive(1'b1, d);
    drive(1'b0, FRAME - d);
  endtask

  task automatic mark();
    sv_b = sv_q.size();
    pv_b = pv_q.size();
    se_b = se_q.size();
  endtask

  task automatic restart();
    en_i = 1'b0; pwm_i = 1'b0; NRST = 1'b0;
    step(); step();
    NRST = 1'b1;
    step();
    en_i = 1'b1;
    drive(1'b0, 4);
    mark();
  endtask

  // Expected strobes from frame duties: sample = min(duty,255); period = strobe
  // distance between armed upward crossings; silence after SIL zero frames.
  task automatic model_frames();
    int  last_cross, zrun, s;
    bit  armed, prev_above, silent, above;
    exp_s.delete(); exp_sil.delete(); exp_pidx.delete(); exp_pval.delete();
    armed = 0; prev_above = 0; silent = 1; zrun = 0; last_cross = 0;
    foreach (duty_a[k]) begin
      s = (duty_a[k] > 255) ? 255 : duty_a[k];
      above = (s >= 128);
      if (s == 0) begin
        zrun++;
        if (zrun >= SIL) begin
          if (!silent) armed = 0;
          silent = 1;
        end
      end else begin
        zrun = 0;
        silent = 0;
      end
      if (above && !prev_above) begin
        if (armed) begin
          exp_pidx.push_back(k);
          exp_pval.push_back(k - last_cross);
        end
        armed = 1;
        last_cross = k;
      end
      prev_above = above;
      exp_s.push_back(s);
      exp_sil.push_back(silent);
    end
  endtask

  task automatic test_reset();
    NRST = 1'b0; en_i = 1'b1;
    pwm_i = 1'b1; step();
    pwm_i = 1'b0; step();
    pwm_i = 1'b1; #10;
    total++; if (sample_o !== '0) $display("FAIL reset_sample: got %0d want 0", sample_o); else passed++;
    total++; if (sample_valid_o !== 1'b0) $display("FAIL reset_svalid: got %b want 0", sample_valid_o); else passed++;
    total++; if (period_o !== '0) $display("FAIL reset_period: got %0d want 0", period_o); else passed++;
    total++; if (period_valid_o !== 1'b0) $display("FAIL reset_pvalid: got %b want 0", period_valid_o); else passed++;
    total++; if (sync_err_o !== 1'b0) $display("FAIL reset_syncerr: got %b want 0", sync_err_o); else passed++;
    total++; if (locked_o !== 1'b0) $display("FAIL reset_locked: got %b want 0", locked_o); else passed++;
    total++; if (silent_o !== 1'b1) $display("FAIL reset_silent: got %b want 1", silent_o); else passed++;
    pwm_i = 1'b0;
  endtask

  task automatic test_steady();
    int t0;
    restart();
    t0 = cyc;
    pwm_i = 1'b1;
    step(); step(); step();
    total++; if (locked_o !== 1'b0) $display("FAIL steady_lock_early: got %b want 0", locked_o); else passed++;
    step();
    total++; if (locked_o !== 1'b1) $display("FAIL steady_lock_4: got %b want 1", locked_o); else passed++;
    drive(1'b1, 60);
    drive(1'b0, 192);
    repeat (3) drive_frame(64);
    drive(1'b0, 4);
    total++; if (sv_q.size() - sv_b !== 4) $display("FAIL steady_count: got %0d want 4", sv_q.size() - sv_b); else passed++;
    for (int k = 0; k < 4 && sv_b + k < sv_q.size(); k++) begin
      total++; if (sv_q[sv_b+k].val !== 64) $display("FAIL steady_val[%0d]: got %0d want 64", k, sv_q[sv_b+k].val); else passed++;
      total++; if (sv_q[sv_b+k].cyc !== t0 + LAT + FRAME*k) $display("FAIL steady_time[%0d]: got %0d want %0d", k, sv_q[sv_b+k].cyc, t0 + LAT + FRAME*k); else passed++;
    end
    total++; if (se_q.size() - se_b !== 0) $display("FAIL steady_syncerr: got %0d want 0", se_q.size() - se_b); else passed++;
    total++; if (silent_o !== 1'b0) $display("FAIL steady_silent: got %b want 0", silent_o); else passed++;
  endtask

  task automatic test_extremes();
    int t0;
    int ev [7] = '{64, 255, 0, 0, 0, 0, 10};
    bit es [7] = '{0, 0, 0, 0, 0, 1, 0};
    restart();
    t0 = cyc;
    drive_frame(64);
    drive_frame(256);
    repeat (4) drive_frame(0);
    drive_frame(10);
    drive(1'b0, 4);
    total++; if (sv_q.size() - sv_b !== 7) $display("FAIL ext_count: got %0d want 7", sv_q.size() - sv_b); else passed++;
    for (int k = 0; k < 7 && sv_b + k < sv_q.size(); k++) begin
      total++; if (sv_q[sv_b+k].val !== ev[k]) $display("FAIL ext_val[%0d]: got %0d want %0d", k, sv_q[sv_b+k].val, ev[k]); else passed++;
      total++; if (sv_q[sv_b+k].sil !== es[k]) $display("FAIL ext_silent[%0d]: got %b want %b", k, sv_q[sv_b+k].sil, es[k]); else passed++;
      total++; if (sv_q[sv_b+k].cyc !== t0 + LAT + FRAME*k) $display("FAIL ext_time[%0d]: got %0d want %0d", k, sv_q[sv_b+k].cyc, t0 + LAT + FRAME*k); else passed++;
    end
    total++; if (pv_q.size() - pv_b !== 0) $display("FAIL ext_period: got %0d strobes want 0", pv_q.size() - pv_b); else passed++;
  endtask

  task automatic test_misalign();
    int t0, ti;
    int et [3];
    restart();
    t0 = cyc;
    drive_frame(64);
    drive(1'b1, 64);
    drive(1'b0, 36);
    ti = cyc;
    drive_frame(64);
    drive_frame(64);
    drive(1'b0, 4);
    et[0] = t0 + LAT; et[1] = ti + LAT; et[2] = ti + LAT + FRAME;
    total++; if (se_q.size() - se_b !== 1) $display("FAIL mis_syncerr_count: got %0d want 1", se_q.size() - se_b); else passed++;
    if (se_q.size() > se_b) begin
      total++; if (se_q[se_b] !== ti + 3) $display("FAIL mis_syncerr_time: got %0d want %0d", se_q[se_b], ti + 3); else passed++;
    end
    total++; if (sv_q.size() - sv_b !== 3) $display("FAIL mis_count: got %0d want 3", sv_q.size() - sv_b); else passed++;
    for (int k = 0; k < 3 && sv_b + k < sv_q.size(); k++) begin
      total++; if (sv_q[sv_b+k].val !== 64) $display("FAIL mis_val[%0d]: got %0d want 64", k, sv_q[sv_b+k].val); else passed++;
      total++; if (sv_q[sv_b+k].cyc !== et[k]) $display("FAIL mis_time[%0d]: got %0d want %0d", k, sv_q[sv_b+k].cyc, et[k]); else passed++;
    end
  endtask

  task automatic test_period();
    int t0;
    restart();
    duty_a.delete();
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 5; i++) duty_a.push_back(200);
      for (int i = 0; i < 5; i++) duty_a.push_back(50);
    end
    model_frames();
    t0 = cyc;
    foreach (duty_a[k]) drive_frame(duty_a[k]);
    drive(1'b0, 4);
    total++; if (sv_q.size() - sv_b !== exp_s.size()) $display("FAIL per_scount: got %0d want %0d", sv_q.size() - sv_b, exp_s.size()); else passed++;
    for (int k = 0; k < exp_s.size() && sv_b + k < sv_q.size(); k++) begin
      total++; if (sv_q[sv_b+k].val !== exp_s[k]) $display("FAIL per_sval[%0d]: got %0d want %0d", k, sv_q[sv_b+k].val, exp_s[k]); else passed++;
    end
    total++; if (pv_q.size() - pv_b !== 3) $display("FAIL per_pcount: got %0d want 3", pv_q.size() - pv_b); else passed++;
    for (int k = 0; k < exp_pval.size() && pv_b + k < pv_q.size(); k++) begin
      total++; if (pv_q[pv_b+k].val !== 10) $display("FAIL per_pval[%0d]: got %0d want 10", k, pv_q[pv_b+k].val); else passed++;
      total++; if (pv_q[pv_b+k].cyc !== t0 + LAT + FRAME*exp_pidx[k] + 1) $display("FAIL per_ptime[%0d]: got %0d want %0d", k, pv_q[pv_b+k].cyc, t0 + LAT + FRAME*exp_pidx[k] + 1); else passed++;
    end
  endtask

  task automatic test_enable_drop();
    int t2;
    restart();
    drive_frame(64);
    drive_frame(64);
    drive(1'b1, 64);
    drive(1'b0, 66);
    en_i = 1'b0;
    mark();
    step();
    total++; if (locked_o !== 1'b0) $display("FAIL en_locked_drop: got %b want 0", locked_o); else passed++;
    total++; if (silent_o !== 1'b1) $display("FAIL en_silent_drop: got %b want 1", silent_o); else passed++;
    drive(1'b0, 125);
    drive_frame(64);
    total++; if (sv_q.size() - sv_b !== 0) $display("FAIL en_no_strobe: got %0d want 0", sv_q.size() - sv_b); else passed++;
    total++; if (sample_o !== 8'd64) $display("FAIL en_sample_hold: got %0d want 64", sample_o); else passed++;
    total++; if (locked_o !== 1'b0) $display("FAIL en_idle_locked: got %b want 0", locked_o); else passed++;
    en_i = 1'b1;
    drive(1'b0, 3);
    mark();
    t2 = cyc;
    drive_frame(100);
    drive(1'b0, 4);
    total++; if (locked_o !== 1'b1) $display("FAIL en_relock: got %b want 1", locked_o); else passed++;
    total++; if (sv_q.size() - sv_b !== 1) $display("FAIL en_relock_count: got %0d want 1", sv_q.size() - sv_b); else passed++;
    if (sv_q.size() > sv_b) begin
      total++; if (sv_q[sv_b].val !== 100) $display("FAIL en_relock_val: got %0d want 100", sv_q[sv_b].val); else passed++;
      total++; if (sv_q[sv_b].cyc !== t2 + LAT) $display("FAIL en_relock_time: got %0d want %0d", sv_q[sv_b].cyc, t2 + LAT); else passed++;
    end
  endtask

  task automatic test_random();
    int t0;
    restart();
    duty_a.delete();
    duty_a.push_back($urandom_range(1, 256));
    for (int i = 1; i < 24; i++) begin
      if ($urandom_range(0, 9) < 3) duty_a.push_back(0);
      else duty_a.push_back($urandom_range(0, 256));
    end
    model_frames();
    t0 = cyc;
    foreach (duty_a[k]) drive_frame(duty_a[k]);
    drive(1'b0, 4);
    total++; if (sv_q.size() - sv_b !== exp_s.size()) $display("FAIL rnd_scount: got %0d want %0d", sv_q.size() - sv_b, exp_s.size()); else passed++;
    for (int k = 0; k < exp_s.size() && sv_b + k < sv_q.size(); k++) begin
      total++; if (sv_q[sv_b+k].val !== exp_s[k]) $display("FAIL rnd_sval[%0d]: got %0d want %0d", k, sv_q[sv_b+k].val, exp_s[k]); else passed++;
      total++; if (sv_q[sv_b+k].sil !== exp_sil[k]) $display("FAIL rnd_silent[%0d]: got %b want %b", k, sv_q[sv_b+k].sil, exp_sil[k]); else passed++;
    end
    total++; if (pv_q.size() - pv_b !== exp_pval.size()) $display("FAIL rnd_pcount: got %0d want %0d", pv_q.size() - pv_b, exp_pval.size()); else passed++;
    for (int k = 0; k < exp_pval.size() && pv_b + k < pv_q.size(); k++) begin
      total++; if (pv_q[pv_b+k].val !== exp_pval[k]) $display("FAIL rnd_pval[%0d]: got %0d want %0d", k, pv_q[pv_b+k].val, exp_pval[k]); else passed++;
      total++; if (pv_q[pv_b+k].cyc !== t0 + LAT + FRAME*exp_pidx[k] + 1) $display("FAIL rnd_ptime[%0d]: got %0d want %0d", k, pv_q[pv_b+k].cyc, t0 + LAT + FRAME*exp_pidx[k] + 1); else passed++;
    end
    total++; if (se_q.size() - se_b !== 0) $display("FAIL rnd_syncerr: got %0d want 0", se_q.size() - se_b); else passed++;
  endtask

  initial begin
    #1;
    test_reset();
    test_steady();
    test_extremes();
    test_misalign();
    test_period();
    test_enable_drop();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pwm_demod.md
# pwm_demod

Receive-side companion to the synthesizer's PWM audio output. The block samples a 1-bit PWM stream, recovers the per-frame duty value as a W-bit audio sample, and tracks the waveform's period in frames for note/frequency checking. It sits downstream of `synth_top`'s `pwm_o`, either on-chip as a loopback monitor or in the verification environment as a reusable checker. It runs on the same 10 MHz system clock.

## Interface
- `W`, 8: sample width. One PWM frame is 2^W clocks.
- `PER_W`, 16: width of the period counter and output.
- `SILENT_FRAMES`, 4: consecutive zero-duty frames before `silent_o` asserts.

- `clk` input 1: system clock, rising-edge active.
- `NRST` input 1: reset, asynchronous, active-low.
- `en_i` input 1: enable. Low forces IDLE.
- `pwm_i` input 1: PWM stream; may be asynchronous.
- `sample_o` output W: last recovered duty sample.
- `sample_valid_o` output 1: one-cycle strobe when `sample_o` updates.
- `period_o` output PER_W: frames between the last two upward midscale crossings.
- `period_valid_o` output 1: one-cycle strobe when `period_o` updates.
- `sync_err_o` output 1: one-cycle strobe on a misaligned rising edge.
- `locked_o` output 1: high in LOCKED.
- `silent_o` output 1: no tone detected.

## Operation
- **Input path:** 2-FF synchronizer produces `pwm_s`; a third FF holds `pwm_d`. `rise = pwm_s & ~pwm_d`.
- **FSM:** two states, IDLE and LOCKED. Reset and `en_i`=0 both force IDLE.
- **IDLE:**
  - `pos`, the high accumulator, the period counter and the period arm flag are all cleared.
  - On `rise` with `en_i`=1: go to LOCKED. That cycle is frame position 0 and the accumulator loads 1.
- **LOCKED, per cycle:**
  - `pos` increments modulo 2^W.
  - The accumulator adds `pwm_s`. It is W+1 bits wide.
- **Frame end (`pos` = 2^W-1):**
  - Total high count includes the current cycle.
  - Load `sample_o` = min(total, 2^W-1). A 256-clock-high frame therefore reports 255.
  - Pulse `sample_valid_o`, then restart the accumulator.
- **Misaligned rise (`rise` while `pos` ≠ 0):**
  - Pulse `sync_err_o`.
  - Discard the partial frame: no sample, no strobe.
  - That cycle becomes `pos` 0 and the accumulator loads 1.
- **No rise at `pos` 0:** legal, e.g. duty 0. The frame completes normally with sample 0.
- **Silence detection:**
  - Count consecutive completed frames with sample 0.
  - When the count reaches `SILENT_FRAMES`, set `silent_o`.
  - Any nonzero sample clears the count and `silent_o`.
  - In IDLE, `silent_o` = 1.
- **Period measurement:**
  - `above` = (sample ≥ 2^(W-1)), evaluated at each sample strobe; `prev_above` is kept from the previous strobe.
  - The frame counter increments per sample strobe and saturates at all-ones.
  - On an upward crossing (`above` & ~`prev_above`):
    - If armed: load `period_o` = counter + 1, pulse `period_valid_o`, reset counter to 0.
    - If not armed: set armed and reset counter to 0.
  - `silent_o` rising disarms the flag.
- **Output holds:**
  - `sample_o` and `period_o` hold their last values through IDLE and silence.
  - Both clear only on reset.

## Timing
- **Reset values:**
  - `sample_o` = 0, `period_o` = 0.
  - All strobes = 0, `locked_o` = 0.
  - `silent_o` = 1, FSM = IDLE.
- **Latency:**
  - `pwm_i` to `pwm_s`: 2 cycles.
  - Rising edge on `pwm_i` to `locked_o` high: 4 cycles.
- **Sample strobe:** `sample_valid_o` is registered. It is high exactly the cycle after the `pos` = 2^W-1 edge. In steady lock it recurs every 2^W cycles.
- **Period strobe:** `period_valid_o` fires 1 cycle after the `sample_valid_o` that completes the crossing.
- **Sync error:** `sync_err_o` is high 1 cycle after the misaligned `rise` cycle.
- **Simultaneous events:**
  - Misaligned rise at `pos` = 2^W-1: `sync_err` wins. No sample is issued.
  - `en_i` falling in the same cycle as frame end: IDLE wins. No strobe.
- **Reset mid-frame:** immediate. There are no partial strobes.
- **Register rule:** all outputs are driven directly from flops.

## Test plan
- **Reset:** hold `NRST`=0 for 2 cycles with `pwm_i` toggling → all outputs at reset values, `locked_o`=0, `silent_o`=1.
- **Steady duty:** `en_i`=1; `pwm_i` high 64 then low 192, repeating → `locked_o` after 4 cycles; `sample_o`=64 with `sample_valid_o` every 256 cycles; `sync_err_o` never asserts.
- **Extremes:**
  - After lock, `pwm_i` held high for 256 clocks → `sample_o`=255.
  - Then `pwm_i` held low → four samples of 0, with `silent_o` rising on the 4th strobe.
  - Then one 10-high frame → `silent_o` clears.
- **Misalignment:** during lock with duty 64, inject a rise at `pos` 100 → `sync_err_o` pulses once; no strobe for the aborted frame; next `sample_valid_o` comes 256 cycles after the injected rise.
- **Period:** frame duties cycle 200×5, 50×5, repeating → first upward crossing only arms; every later crossing gives `period_o`=10 with `period_valid_o` one cycle after the sample strobe.
- **Enable drop:** drop `en_i` at `pos` 128 → `locked_o` low next cycle; no strobes; `silent_o`=1; `sample_o` holds. Re-raise `en_i` → relock on the next rise, and the next sample is correct 256 cycles after lock.
